// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller for the alu12 address path: one instruction at a time,
// address capture, memory request/ready handshake with watchdog, and a single RF write for loads.
module lsu_ctrl #(
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [5:0]    opcode,
   input  logic [7:0]    sub_opcode_8bit,
   input  logic [DW-1:0] store_data,
   input  logic [11:0]   alu_result,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_rdata,
   output logic          enable_execute,
   output logic          mem_req,
   output logic          mem_we,
   output logic [11:0]   mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          rf_we,
   output logic [DW-1:0] rf_wdata,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_REQ  = 3'd2;
   localparam logic [2:0] S_WB   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [5:0] OP_LWI     = 6'b000010;
   localparam logic [5:0] OP_SWI     = 6'b001010;
   localparam logic [5:0] OP_TYPE_LS = 6'b011100;
   localparam logic [7:0] SUB_LW     = 8'b00000010;
   localparam logic [7:0] SUB_SW     = 8'b00001010;

   // Last watchdog value before abort: REQ lasts at most TIMEOUT cycles.
   localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

   logic [2:0] state;
   logic       is_store;
   logic       err_flag;
   logic [7:0] wdog;
   logic       dec_load;
   logic       dec_store;

   always_comb begin
      dec_load  = (opcode == OP_LWI) ||
                  ((opcode == OP_TYPE_LS) && (sub_opcode_8bit == SUB_LW));
      dec_store = (opcode == OP_SWI) ||
                  ((opcode == OP_TYPE_LS) && (sub_opcode_8bit == SUB_SW));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         is_store  <= 1'b0;
         err_flag  <= 1'b0;
         wdog      <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rf_wdata  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (dec_load || dec_store) begin
                     state     <= S_ADDR;
                     is_store  <= dec_store;
                     mem_wdata <= store_data;
                  end else begin
                     state    <= S_DONE;
                     err_flag <= 1'b1;
                  end
               end
            end
            S_ADDR: begin
               mem_addr <= alu_result;
               wdog     <= '0;
               state    <= S_REQ;
            end
            S_REQ: begin
               // Ready takes priority over the watchdog in the final REQ cycle.
               if (mem_ready) begin
                  if (is_store) begin
                     state <= S_DONE;
                  end else begin
                     rf_wdata <= mem_rdata;
                     state    <= S_WB;
                  end
               end else if (wdog == WDOG_LAST) begin
                  err_flag <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  wdog <= wdog + 8'd1;
               end
            end
            S_WB: begin
               state <= S_DONE;
            end
            S_DONE: begin
               err_flag <= 1'b0;
               state    <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign enable_execute = (state == S_ADDR);
   assign mem_req        = (state == S_REQ);
   assign mem_we         = (state == S_REQ) && is_store;
   assign rf_we          = (state == S_WB);
   assign busy           = (state != S_IDLE);
   assign done           = (state == S_DONE);
   assign err            = (state == S_DONE) && err_flag;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencing controller for the 12-bit address ALU (`alu12`) in the P2 datapath. It accepts one decoded load/store instruction at a time, drives `enable_execute` for exactly one address-generation cycle, and latches the ALU address. It then runs a request/ready handshake with data memory and, for loads, issues a single register-file write. A watchdog aborts memory accesses that never complete.

## Interface
- `DW`, 32: data width of memory and register-file data.
- `TIMEOUT`, 15: maximum cycles in REQ before abort; legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: instruction valid; sampled only in IDLE.
- `opcode` input 6: primary opcode of the instruction.
- `sub_opcode_8bit` input 8: sub-opcode; used only when `opcode`=011100 (TYPE_LS).
- `store_data` input DW: register value to store; latched with `start`.
- `alu_result` input 12: address from `alu12`; valid while `enable_execute`=1.
- `mem_ready` input 1: memory completes the access in this cycle.
- `mem_rdata` input DW: read data; valid when `mem_ready`=1 on a load.
- `enable_execute` output 1: ALU enable; driven to `alu12`.
- `mem_req` output 1: memory access request.
- `mem_we` output 1: 1 for a store, 0 for a load; valid while `mem_req`=1.
- `mem_addr` output 12: latched access address.
- `mem_wdata` output DW: latched store data.
- `rf_we` output 1: one-cycle register-file write strobe for loads.
- `rf_wdata` output DW: load data; valid while `rf_we`=1.
- `busy` output 1: high from the cycle after an accepted `start` until the cycle after `done`.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: qualifies `done`. 1 means an illegal opcode or a timeout.

## Operation
- Decode at `start` in IDLE:
  - Load when `opcode`=000010 (LWI), or `opcode`=011100 with `sub_opcode_8bit`=00000010 (LW).
  - Store when `opcode`=001010 (SWI), or `opcode`=011100 with `sub_opcode_8bit`=00001010 (SW).
  - Everything else is illegal.
  - Latch `store_data` and the load/store kind on acceptance.
- FSM states are IDLE, ADDR, REQ, WB and DONE.
- IDLE:
  - `start`=1 with a legal opcode: go to ADDR.
  - `start`=1 with an illegal opcode: go to DONE with err flag set.
  - Otherwise: stay in IDLE.
- ADDR (exactly 1 cycle): `enable_execute`=1. Capture `alu_result` into `mem_addr` at the end of the cycle, then go to REQ.
- REQ:
  - `mem_req`=1; `mem_we`, `mem_addr` and `mem_wdata` are held stable.
  - Watchdog counter is cleared on entry and increments each REQ cycle with `mem_ready`=0.
  - `mem_ready`=1 on a load: capture `mem_rdata`, go to WB.
  - `mem_ready`=1 on a store: go to DONE.
  - Counter reaches `TIMEOUT` with no ready: go to DONE with err flag set.
  - `mem_ready` in the same cycle the counter reaches `TIMEOUT`: ready wins and the access completes normally.
- WB (1 cycle): `rf_we`=1, `rf_wdata` = captured data. Go to DONE.
- DONE (1 cycle): `done`=1, `err` = err flag. Go to IDLE; the err flag clears on leaving DONE.
- `start` outside IDLE is ignored and never queued. `mem_ready` outside REQ is ignored.
- `enable_execute`, `mem_req` and `rf_we` are mutually exclusive in every cycle.

## Timing
- Reset values: state IDLE; every output 0, including `mem_addr`, `mem_wdata` and `rf_wdata`; watchdog counter 0.
- Reset mid-operation, in any state: return to IDLE in the next cycle. `mem_req` drops immediately, no `done` is produced, and no RF write is issued.
- Cycle numbering: `start` is accepted at cycle T.
  - ADDR at T+1, first REQ cycle at T+2.
  - Load with ready at T+2+k (k ≥ 0): WB at T+3+k, `done` at T+4+k.
  - Store with ready at T+2+k: `done` at T+3+k.
  - Illegal opcode: `done`+`err` at T+1. `enable_execute` and `mem_req` never assert.
  - Timeout: `mem_req` stays high for `TIMEOUT` cycles (T+2 .. T+1+`TIMEOUT`), then `done`+`err` at T+2+`TIMEOUT`.
- Back-to-back: a new `start` is accepted in IDLE the cycle after `done`. Minimum spacing is 4 cycles per store and 5 per load.

## Test plan
- Reset, then load LWI (`opcode`=000010), `alu_result`=0x123, `mem_ready` high in the first REQ cycle, `mem_rdata`=0xDEADBEEF:
  - `enable_execute` at T+1.
  - `mem_req`=1, `mem_we`=0, `mem_addr`=0x123 at T+2.
  - `rf_we`=1 with 0xDEADBEEF at T+3.
  - `done`=1, `err`=0 at T+4.
- Store SW (`opcode`=011100, `sub`=00001010), `store_data`=0x0000A5A5, `mem_ready` delayed 3 cycles:
  - `mem_req`=1, `mem_we`=1, `mem_wdata`=0xA5A5 held from T+2 to T+5.
  - `done` at T+6; `rf_we` never asserts.
- Illegal instruction (`opcode`=101000 ADDI) → `done`=1, `err`=1 at T+1; `enable_execute` and `mem_req` never assert.
- Timeout with `TIMEOUT`=15 and `mem_ready` held 0:
  - `mem_req` high for exactly 15 cycles.
  - `done`+`err` at T+17.
  - A subsequent load completes normally with `err`=0.
- `reset` asserted during REQ of a load → the next cycle shows all outputs 0 and `busy`=0, with no `done` and no `rf_we`. `start` pulsed while busy is ignored: exactly one `done` per accepted instruction.
